// File: rtl/multdiv_if.sv
// Operand/control/result bundle between the execute-stage pipeline and the multdiv unit.
// Handshake: ctrl_MULT/ctrl_DIV are one-cycle start pulses. Operands are captured on the
// same rising edge. data_resultRDY is a one-cycle pulse that qualifies data_result and
// data_exception. busy is high while an operation is in flight. A start while busy aborts
// the operation in flight. There is no backpressure.
interface multdiv_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;
  logic [1:0]       state_dbg;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy, state_dbg
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy, state_dbg
  );
endinterface

// File: rtl/multdiv.sv
// Multi-cycle signed multiply (radix-4 Booth) / divide (restoring) unit.
// Results are written to the register file on the data_resultRDY pulse.
module multdiv #(
  parameter int WIDTH        = 32,
  parameter int MULT_LATENCY = 17,
  parameter int DIV_LATENCY  = 33
) (
  input  logic      clock,
  input  logic      ctrl_reset,
  multdiv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [5:0] MUL_LAST = 6'(MULT_LATENCY - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_LATENCY - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_next;
  logic [5:0] cnt;
  logic       zero_pend;

  logic start_mul, start_div, start_any, div_zero;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH:0]     mq;
  logic [2*WIDTH-1:0] booth_add;

  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dd;
  logic [WIDTH-1:0] rem;
  logic             neg;
  logic             ovf;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] abs_a, abs_b;

  logic [WIDTH-1:0] result;
  logic             exc;

  assign start_mul = bus.ctrl_MULT;
  assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
  assign start_any = bus.ctrl_MULT | bus.ctrl_DIV;
  assign div_zero  = (bus.data_operandB == '0);

  assign abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) state <= IDLE;
    else            state <= state_next;
  end

  // A start pulse overrides whatever is in flight; a zero divisor spends one
  // pending cycle in IDLE before presenting its result.
  always_comb begin
    state_next = state;
    if (start_mul) begin
      state_next = MUL_RUN;
    end else if (start_div) begin
      state_next = div_zero ? IDLE : DIV_RUN;
    end else begin
      unique case (state)
        IDLE:    if (zero_pend) state_next = DONE;
        MUL_RUN: if (cnt == MUL_LAST) state_next = DONE;
        DIV_RUN: if (cnt == DIV_LAST) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      cnt       <= '0;
      zero_pend <= 1'b0;
    end else begin
      zero_pend <= start_div & div_zero;
      if (start_any)                                  cnt <= '0;
      else if (state == MUL_RUN || state == DIV_RUN)  cnt <= cnt + 6'd1;
      else                                            cnt <= '0;
    end
  end

  // Booth digit from multiplier bits (2i+1, 2i, 2i-1).
  always_comb begin
    booth_add = '0;
    unique case (mq[2:0])
      3'b001, 3'b010: booth_add = mcand;
      3'b011:         booth_add = mcand << 1;
      3'b100:         booth_add = -(mcand << 1);
      3'b101, 3'b110: booth_add = -mcand;
      default:        booth_add = '0;
    endcase
  end

  assign rem_shift = {rem, dq[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dd};

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      acc    <= '0;
      mcand  <= '0;
      mq     <= '0;
      dq     <= '0;
      dd     <= '0;
      rem    <= '0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
      exc    <= 1'b0;
    end else begin
      if (start_mul) begin
        acc   <= '0;
        mcand <= {{WIDTH{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
        mq    <= {bus.data_operandB, 1'b0};
      end else if (start_div) begin
        dq  <= abs_a;
        dd  <= abs_b;
        rem <= '0;
        neg <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        ovf <= (bus.data_operandA == MIN_NEG) && (bus.data_operandB == '1);
      end else if (state == MUL_RUN && cnt < MUL_LAST) begin
        acc   <= acc + booth_add;
        mcand <= mcand << 2;
        mq    <= {{2{mq[WIDTH]}}, mq[WIDTH:2]};
      end else if (state == DIV_RUN && cnt < DIV_LAST) begin
        if (!rem_diff[WIDTH]) begin
          rem <= rem_diff[WIDTH-1:0];
          dq  <= {dq[WIDTH-2:0], 1'b1};
        end else begin
          rem <= rem_shift[WIDTH-1:0];
          dq  <= {dq[WIDTH-2:0], 1'b0};
        end
      end

      if (state_next == DONE) begin
        unique case (state)
          MUL_RUN: begin
            result <= acc[WIDTH-1:0];
            exc    <= (acc[2*WIDTH-1:WIDTH] != {WIDTH{acc[WIDTH-1]}});
          end
          DIV_RUN: begin
            result <= neg ? -dq : dq;
            exc    <= ovf;
          end
          default: begin
            result <= '0;
            exc    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.data_result    = result;
  assign bus.data_exception = exc;
  assign bus.data_resultRDY = (state == DONE);
  assign bus.busy           = (state == MUL_RUN) || (state == DIV_RUN) || zero_pend;
  assign bus.state_dbg      = state;

endmodule

// File: tb/tb_multdiv.sv
// Scoreboard bench for multdiv: a driver pushes model results and arrival cycles,
// and a negedge monitor pops and compares them on every data_resultRDY pulse.
module tb_multdiv;
  localparam int MLAT = 17;
  localparam int DLAT = 33;

  logic clock = 1'b0;
  logic ctrl_reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [32:0] mon_e;
  int          mon_ec;
  logic [32:0] drop_e;
  int          drop_c;

  multdiv_if #(.WIDTH(32)) bus();

  multdiv #(.WIDTH(32), .MULT_LATENCY(MLAT), .DIV_LATENCY(DLAT)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus.slave)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain signed arithmetic; returns {exception, result}.
  function automatic logic [32:0] model(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [31:0] lo;
    int q;
    if (is_mul) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      lo = p[31:0];
      return {(p != longint'($signed(lo))), lo};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    return {1'b0, 32'(q)};
  endfunction

  function automatic int latency(input bit is_mul, input logic [31:0] b);
    if (is_mul) return MLAT;
    if (b == 32'd0) return 1;
    return DLAT;
  endfunction

  // Driver: call at a negedge. Any operation still in flight is aborted by this start.
  task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    #1;
    if (exp_q.size() > 0) begin
      drop_e = exp_q.pop_back();
      drop_c = exp_cyc_q.pop_back();
    end
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    exp_q.push_back(model(m, a, b));
    exp_cyc_q.push_back(cyc + 1 + latency(m, b));
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    check("busy_after_start", {63'd0, bus.busy}, 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_result"}, {32'd0, bus.data_result}, 64'd0);
    check({tag, "_exception"}, {63'd0, bus.data_exception}, 64'd0);
    check({tag, "_rdy"}, {63'd0, bus.data_resultRDY}, 64'd0);
    check({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] sp[6];
    sp = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h7FFF_FFFF, 32'h0001_0000};
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 200)) - 32'd100;
      1:       return $urandom;
      2:       return sp[$urandom_range(0, 5)];
      default: return 32'($urandom_range(0, 65535));
    endcase
  endfunction

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (!ctrl_reset) begin
      if (bus.data_resultRDY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rdy", {63'd0, bus.data_resultRDY}, 64'd0);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_ec = exp_cyc_q.pop_front();
          check("result", {32'd0, bus.data_result}, {32'd0, mon_e[31:0]});
          check("exception", {63'd0, bus.data_exception}, {63'd0, mon_e[32]});
          check("latency", 64'(cyc), 64'(mon_ec));
          check("busy_in_rdy", {63'd0, bus.busy}, 64'd0);
        end
      end else if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
        check("missing_rdy", {63'd0, bus.data_resultRDY}, 64'd1);
        mon_e  = exp_q.pop_front();
        mon_ec = exp_cyc_q.pop_front();
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    bit m, d;
    int mode, k;
    ctrl_reset        = 1'b1;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    repeat (3) @(negedge clock);
    check_zero_outputs("reset");
    ctrl_reset = 1'b0;
    repeat (3) @(negedge clock);
    check_zero_outputs("idle");

    // Directed cases
    @(negedge clock); issue(1, 0, 32'd7, 32'hFFFF_FFFD);           wait_drain();
    check("busy_after_mul", {63'd0, bus.busy}, 64'd0);
    @(negedge clock); issue(1, 0, 32'h0001_0000, 32'h0001_0000);   wait_drain();
    @(negedge clock); issue(0, 1, 32'hFFFF_FF9C, 32'd7);           wait_drain();
    @(negedge clock); issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);   wait_drain();
    @(negedge clock); issue(0, 1, 32'd5, 32'd0);                   wait_drain();
    @(negedge clock); issue(1, 1, 32'd9, 32'd3);                   wait_drain();

    // Abort a multiply with a divide five cycles later
    @(negedge clock); issue(1, 0, 32'd3, 32'd4);
    repeat (5) @(negedge clock);
    issue(0, 1, 32'd100, 32'd10);
    wait_drain();

    // Reset mid-operation
    @(negedge clock); issue(1, 0, 32'd6, 32'd7);
    repeat (9) @(negedge clock);
    ctrl_reset = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    check_zero_outputs("midreset");
    @(negedge clock);
    ctrl_reset = 1'b0;
    repeat (25) @(negedge clock);
    check("post_reset_busy", {63'd0, bus.busy}, 64'd0);
    issue(1, 0, 32'd6, 32'd7);
    wait_drain();

    // Randomized: back-to-back, aborts, and starts inside the ready cycle
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 9);
      m    = 1'($urandom_range(0, 1));
      d    = !m || ($urandom_range(0, 4) == 0);
      if (mode < 2) begin
        repeat ($urandom_range(1, 12)) @(negedge clock);
      end else if (mode < 4) begin
        k = 0;
        do begin
          @(negedge clock);
          k++;
        end while (!bus.data_resultRDY && exp_q.size() > 0 && k < 100);
      end else begin
        wait_drain();
      end
      issue(m, d, rand_op(), rand_op());
    end
    wait_drain();
    repeat (3) @(negedge clock);
    check("final_busy", {63'd0, bus.busy}, 64'd0);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
